instruction_fetch_unit: RTL and testbench

Producer side of the opcode path: fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, holds the current instruction and drives its `[31:26]` field as `opcode` into `Control_unit`, then computes the next PC from the branch/jump decisions returned for that same instruction. It sits between instruction memory and the decode/execute stage of the multi-cycle datapath and owns the architectural PC.

---
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, holds the word for decode.
// Optional IFU_HALT_EN: opcode 6'b111111 parks the unit in HALTED until reset.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] pc,
   output logic        halted,
   output logic [1:0]  o_dbg_state
);

   // Handshakes: memory side is req/ack, with req and addr held until the ack edge.
   // Decode side is valid/ready, and branch/zero/jump are only meaningful on the ready edge.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
`ifdef IFU_HALT_EN
      , S_HALTED = 2'd3
`endif
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_req;
   logic        r_valid;

   logic [31:0] w_pc4;
   logic [31:0] w_jump_target;
   logic [31:0] w_br_offset;
   logic [31:0] w_br_target;
   logic [31:0] w_next_pc;

   assign w_pc4         = r_pc + 32'd4;
   assign w_jump_target = {w_pc4[31:28], r_instr[25:0], 2'b00};
   assign w_br_offset   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_br_target   = w_pc4 + w_br_offset;

   // Jump outranks a taken branch.
   always_comb begin
      w_next_pc = w_pc4;
      if (jump)
         w_next_pc = w_jump_target;
      else if (branch && zero)
         w_next_pc = w_br_target;
   end

`ifdef IFU_HALT_EN
   logic r_halted;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
`ifdef IFU_HALT_EN
         r_halted <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req   <= 1'b1;
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  r_valid <= 1'b0;
`ifdef IFU_HALT_EN
                  if (r_instr[31:26] == 6'b111111) begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALTED;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_req   <= 1'b1;
                     r_state <= S_FETCH;
                  end
`else
                  r_pc    <= w_next_pc;
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
`endif
               end
            end
`ifdef IFU_HALT_EN
            S_HALTED: begin
               r_state <= S_HALTED;
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign opcode      = r_instr[31:26];
   assign instr_valid = r_valid;
   assign pc          = r_pc;
   assign o_dbg_state = r_state;
`ifdef IFU_HALT_EN
   assign halted = r_halted;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with address/instruction scoreboards.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] pc;
   logic        halted;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_i_q[$];
   logic [31:0] cur_pc;

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .pc          (pc),
      .halted      (halted),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_instr"}, instr,                32'd0);
      chk({tag, "_pc"},    pc,                   32'd0);
      chk({tag, "_halt"},  {31'd0, halted},      32'd0);
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic fetch_instr(input int delay, input logic [31:0] data);
      bit          ok;
      logic [31:0] a;
      logic [31:0] e;
      wait_req(ok);
      chk("req_seen", {31'd0, ok}, 32'd1);
      if (!ok || exp_q.size() == 0) begin
         chk("addr_queue", exp_q.size(), 32'd1);
         return;
      end
      a = exp_q.pop_front();
      cur_pc = a;
      chk("imem_addr", imem_addr, a);
      chk("pc_fetch", pc, a);
      chk("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("req_held", {31'd0, imem_req}, 32'd1);
         chk("addr_held", imem_addr, a);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      exp_i_q.push_back(data);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      e = exp_i_q.pop_front();
      chk("instr_valid", {31'd0, instr_valid}, 32'd1);
      chk("req_drop", {31'd0, imem_req}, 32'd0);
      chk("instr", instr, e);
      chk("opcode", {26'd0, opcode}, {26'd0, e[31:26]});
   endtask

   // Sits in HOLD with noise on ack and the control inputs; nothing may change.
   task automatic hold_idle(input int n);
      logic [31:0] held;
      held = instr;
      for (int i = 0; i < n; i++) begin
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         branch     = 1'($urandom_range(0, 1));
         zero       = 1'($urandom_range(0, 1));
         jump       = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("hold_instr", instr, held);
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_pc", pc, cur_pc);
      end
      imem_ack = 1'b0;
   endtask

   task automatic accept(input logic b, input logic z, input logic j, input logic [31:0] nxt);
      exp_q.push_back(nxt);
      instr_ready = 1'b1;
      branch      = b;
      zero        = z;
      jump        = j;
      @(negedge clk);
      instr_ready = 1'b0;
      branch      = 1'($urandom_range(0, 1));
      zero        = 1'($urandom_range(0, 1));
      jump        = 1'($urandom_range(0, 1));
      chk("valid_drop", {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      bit ok;
      reset       = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      instr_ready = 1'b0;
      branch      = 1'b0;
      zero        = 1'b0;
      jump        = 1'b0;
      cur_pc      = 32'd0;

      @(negedge clk);
      chk_cleared("reset");
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back(32'h0000_0000);
      @(negedge clk);
      chk("req_after_reset", {31'd0, imem_req}, 32'd1);

      fetch_instr(0, 32'h0000_0020);
      accept(1'b0, 1'b0, 1'b0, 32'h0000_0004);
      fetch_instr(3, 32'h8C01_0004);
      hold_idle(3);
      accept(1'b0, 1'b0, 1'b0, 32'h0000_0008);
      fetch_instr(0, 32'h1000_FFFE);
      accept(1'b1, 1'b1, 1'b0, 32'h0000_0004);
      fetch_instr(1, 32'h0000_0000);
      accept(1'b0, 1'b0, 1'b0, 32'h0000_0008);
      fetch_instr(0, 32'h1000_FFFE);
      accept(1'b1, 1'b0, 1'b0, 32'h0000_000C);
      fetch_instr(2, 32'h0BFF_FFFF);
      accept(1'b0, 1'b0, 1'b1, 32'h0FFF_FFFC);
      fetch_instr(0, 32'h0800_0000);
      accept(1'b0, 1'b0, 1'b1, 32'h1000_0000);
      fetch_instr(0, 32'h0800_0010);
      accept(1'b1, 1'b1, 1'b1, 32'h1000_0040);
      fetch_instr(0, 32'h0000_0000);

      // Reset while an instruction is held.
      reset = 1'b1;
      #1;
      chk_cleared("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
      @(negedge clk);
      chk("req_after_rst_hold", {31'd0, imem_req}, 32'd1);

      fetch_instr(0, 32'h1000_FFFE);
      accept(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
      fetch_instr(0, 32'h0000_0001);
      accept(1'b0, 1'b0, 1'b0, 32'h0000_0000);

      // Reset in FETCH with an ack arriving while reset is high.
      wait_req(ok);
      chk("req_before_rst_fetch", {31'd0, ok}, 32'd1);
      exp_q.delete();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      reset      = 1'b1;
      #1;
      chk_cleared("rst_fetch");
      @(negedge clk);
      chk_cleared("rst_fetch_ack");
      reset = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("req_after_rst_fetch", {31'd0, imem_req}, 32'd1);
      chk("valid_after_rst_fetch", {31'd0, instr_valid}, 32'd0);
      chk("instr_after_rst_fetch", instr, 32'd0);
      exp_q.push_back(32'h0000_0000);

      fetch_instr(0, 32'h0000_0000);
      accept(1'b0, 1'b0, 1'b0, 32'h0000_0004);
      fetch_instr(0, 32'hFC00_0000);
`ifdef IFU_HALT_EN
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("halted", {31'd0, halted}, 32'd1);
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         chk("halt_valid", {31'd0, instr_valid}, 32'd0);
         chk("halt_pc", pc, 32'h0000_0004);
         @(negedge clk);
      end
`else
      accept(1'b0, 1'b0, 1'b0, 32'h0000_0008);
      fetch_instr(0, 32'h0000_0000);
      chk("not_halted", {31'd0, halted}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
